// File: rtl/vu_pkg.sv
// Shared definitions for the VU bar renderer: peak FSM states, RGB332 palette, bar geometry.
package vu_pkg;

    typedef enum logic {
        S_HOLD  = 1'b0,
        S_DECAY = 1'b1
    } peak_state_e;

    localparam int unsigned BarWidth = 512;

    // RGB332 packed as {r[2:0], g[2:0], b[1:0]}
    localparam logic [7:0] ColGreenLit  = 8'b000_111_00;
    localparam logic [7:0] ColYellowLit = 8'b111_111_00;
    localparam logic [7:0] ColRedLit    = 8'b111_000_00;
    localparam logic [7:0] ColGreenDim  = 8'b000_010_00;
    localparam logic [7:0] ColYellowDim = 8'b010_010_00;
    localparam logic [7:0] ColRedDim    = 8'b010_000_00;
    localparam logic [7:0] ColWhite     = 8'b111_111_11;
    localparam logic [7:0] ColBlack     = 8'b000_000_00;

endpackage

// File: rtl/vu_peak_hold.sv
// Peak-hold tracker: holds the highest frame level for HoldFrames frames, then decays toward it.
module vu_peak_hold
    import vu_pkg::*;
#(
    parameter int unsigned HoldFrames = 30,
    parameter int unsigned Decay      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start_i,
    input  logic [7:0] level_i,
    output logic [7:0] peak_o
);

    localparam int unsigned CntW = $clog2(HoldFrames + 1);

    peak_state_e     state_q;
    logic [7:0]      peak_q;
    logic [CntW-1:0] hold_cnt_q;

    logic [8:0] diff;
    logic [7:0] dec_sat;
    logic [7:0] dec_val;

    // Saturate at zero, then never drop below the current frame level.
    always_comb begin
        diff    = {1'b0, peak_q} - 9'(Decay);
        dec_sat = diff[8] ? 8'd0 : diff[7:0];
        dec_val = (dec_sat > level_i) ? dec_sat : level_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HOLD;
            peak_q     <= 8'd0;
            hold_cnt_q <= '0;
        end else if (frame_start_i) begin
            if (level_i >= peak_q) begin
                peak_q     <= level_i;
                hold_cnt_q <= CntW'(HoldFrames);
                state_q    <= S_HOLD;
            end else begin
                unique case (state_q)
                    S_HOLD: begin
                        if (hold_cnt_q != '0) hold_cnt_q <= hold_cnt_q - 1'b1;
                        else                  state_q    <= S_DECAY;
                    end
                    S_DECAY: peak_q <= dec_val;
                    default: state_q <= S_HOLD;
                endcase
            end
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/vu_bar_renderer.sv
// Horizontal VU bar pixel stage with registered RGB332 output and frame-synchronous level update.
// Optional peak-hold marker is built only when VU_PEAK_HOLD_EN is defined.
module vu_bar_renderer
    import vu_pkg::*;
#(
    parameter int unsigned BarX0      = 64,
    parameter int unsigned BarY0      = 208,
    parameter int unsigned BarH       = 64,
    parameter int unsigned YelTh      = 160,
    parameter int unsigned RedTh      = 220,
    parameter int unsigned HoldFrames = 30,
    parameter int unsigned Decay      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] pix_x_i,
    input  logic [9:0] pix_y_i,
    input  logic       de_i,
    input  logic       frame_start_i,
    input  logic [7:0] level_i,
    input  logic       level_valid_i,
    output logic [2:0] red_o,
    output logic [2:0] green_o,
    output logic [1:0] blue_o,
    output logic       de_out_o
);

    logic [7:0] pending_q, pending_d;
    logic [7:0] disp_q, disp_d;
    logic [7:0] frame_level;
    logic [7:0] rgb_q, rgb_d;
    logic       de_q;

    logic       in_bar;
    logic [9:0] dx;
    logic [7:0] idx;
    logic       marker;

    // A level arriving with frame_start bypasses pending so it shows this frame.
    always_comb begin
        frame_level = level_valid_i ? level_i : pending_q;
        pending_d   = level_valid_i ? level_i : pending_q;
        disp_d      = frame_start_i ? frame_level : disp_q;
    end

`ifdef VU_PEAK_HOLD_EN
    logic [7:0] peak;

    vu_peak_hold #(
        .HoldFrames (HoldFrames),
        .Decay      (Decay)
    ) u_peak_hold (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .level_i       (frame_level),
        .peak_o        (peak)
    );

    assign marker = (idx == peak) && (peak != 8'd0);
`else
    assign marker = 1'b0;
`endif

    always_comb begin
        dx     = pix_x_i - 10'(BarX0);
        idx    = 8'(dx >> 1);
        in_bar = de_i
              && (pix_y_i >= 10'(BarY0)) && (pix_y_i < 10'(BarY0 + BarH))
              && (pix_x_i >= 10'(BarX0)) && (pix_x_i < 10'(BarX0 + BarWidth));
        rgb_d  = ColBlack;
        if (in_bar) begin
            if (marker) begin
                rgb_d = ColWhite;
            end else if (idx < disp_q) begin
                if (idx < 8'(YelTh))      rgb_d = ColGreenLit;
                else if (idx < 8'(RedTh)) rgb_d = ColYellowLit;
                else                      rgb_d = ColRedLit;
            end else begin
                if (idx < 8'(YelTh))      rgb_d = ColGreenDim;
                else if (idx < 8'(RedTh)) rgb_d = ColYellowDim;
                else                      rgb_d = ColRedDim;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 8'd0;
            disp_q    <= 8'd0;
            rgb_q     <= ColBlack;
            de_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            disp_q    <= disp_d;
            rgb_q     <= rgb_d;
            de_q      <= de_i;
        end
    end

    assign red_o    = rgb_q[7:5];
    assign green_o  = rgb_q[4:2];
    assign blue_o   = rgb_q[1:0];
    assign de_out_o = de_q;

endmodule

// File: tb/tb_vu_bar_renderer.sv
// Directed self-checking bench for vu_bar_renderer; peak scenarios run only with VU_PEAK_HOLD_EN.
module tb_vu_bar_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       de = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] level = '0;
    logic       level_valid = 1'b0;
    logic [2:0] red_o;
    logic [2:0] green_o;
    logic [1:0] blue_o;
    logic       de_out_o;

    int checks = 0;
    int failures = 0;

    // {de_out, r, g, b}
    localparam logic [8:0] GL = 9'h11C;
    localparam logic [8:0] GD = 9'h108;
    localparam logic [8:0] YL = 9'h1FC;
    localparam logic [8:0] YD = 9'h148;
    localparam logic [8:0] RL = 9'h1E0;
    localparam logic [8:0] RD = 9'h140;
    localparam logic [8:0] WH = 9'h1FF;
    localparam logic [8:0] BG = 9'h100;
    localparam logic [8:0] OFF = 9'h000;

    vu_bar_renderer dut (
        .clk           (clk),
        .rst           (rst),
        .pix_x_i       (pix_x),
        .pix_y_i       (pix_y),
        .de_i          (de),
        .frame_start_i (frame_start),
        .level_i       (level),
        .level_valid_i (level_valid),
        .red_o         (red_o),
        .green_o       (green_o),
        .blue_o        (blue_o),
        .de_out_o      (de_out_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_level(input int v);
        level = 8'(v);
        level_valid = 1'b1;
        tick();
        level_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic px(input int x, input int y, input logic d, input string tag,
                      input logic [8:0] exp);
        pix_x = 10'(x);
        pix_y = 10'(y);
        de = d;
        tick();
        check(tag, {de_out_o, red_o, green_o, blue_o}, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] peak_or;
        // Reset state
        tick();
        check("reset_out", {de_out_o, red_o, green_o, blue_o}, OFF);
        rst = 1'b0;
        px(64, 220, 1'b1, "rst_level0_idx0", GD);
        px(65, 220, 1'b1, "rst_level0_idx0b", GD);

        // Lit/dim edge at level 100
        set_level(100);
        frame();
        px(263, 220, 1'b1, "edge_lit_263", GL);
`ifdef VU_PEAK_HOLD_EN
        peak_or = WH;
`else
        peak_or = GD;
`endif
        px(264, 220, 1'b1, "edge_264", peak_or);
        px(266, 220, 1'b1, "edge_dim_266", GD);

        // Zone colours
        set_level(240);
        frame();
        px(404, 220, 1'b1, "zone_yel_lit", YL);
        px(524, 220, 1'b1, "zone_red_lit", RL);
        set_level(200);
        frame();
        px(524, 220, 1'b1, "zone_red_dim", RD);
        px(463, 220, 1'b1, "zone_yel_lit_199", YL);
        px(466, 220, 1'b1, "zone_yel_dim_201", YD);

        // Level 255 and geometry boundaries
        set_level(255);
        frame();
        px(573, 220, 1'b1, "full_lit_573", RL);
`ifdef VU_PEAK_HOLD_EN
        peak_or = WH;
`else
        peak_or = RD;
`endif
        px(574, 220, 1'b1, "full_574", peak_or);
        px(576, 220, 1'b1, "bg_right", BG);
        px(63, 220, 1'b1, "bg_left", BG);
        px(300, 207, 1'b1, "bg_above", BG);
        px(300, 272, 1'b1, "bg_below", BG);
        px(300, 271, 1'b1, "bar_last_line", GL);

        // Blanking inside the bar
        px(300, 220, 1'b0, "blank", OFF);

        // Asynchronous reset mid-frame
        px(300, 220, 1'b1, "pre_reset", GL);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {de_out_o, red_o, green_o, blue_o}, OFF);
        tick();
        rst = 1'b0;
        px(64, 220, 1'b1, "post_reset_disp", GD);
        frame();
        px(64, 220, 1'b1, "post_reset_pending", GD);

        // Simultaneous level_valid and frame_start
        set_level(40);
        level = 8'd80;
        level_valid = 1'b1;
        frame_start = 1'b1;
        tick();
        level_valid = 1'b0;
        frame_start = 1'b0;
        px(222, 220, 1'b1, "bypass_lit_79", GL);
        px(226, 220, 1'b1, "bypass_dim_81", GD);
        frame();
        px(222, 220, 1'b1, "bypass_pending", GL);
`ifdef VU_PEAK_HOLD_EN
        px(224, 220, 1'b1, "bypass_marker", WH);

        // Peak hold and decay
        do_reset();
        set_level(200);
        frame();
        px(464, 220, 1'b1, "peak_f0", WH);
        set_level(50);
        for (int n = 1; n <= 120; n++) begin
            frame();
            if (n == 30) px(464, 220, 1'b1, "peak_f30", WH);
            if (n == 31) px(464, 220, 1'b1, "peak_f31", WH);
            if (n == 32) begin
                px(460, 220, 1'b1, "peak_f32_198", WH);
                px(464, 220, 1'b1, "peak_f32_old", YD);
            end
            if (n == 33) px(456, 220, 1'b1, "peak_f33_196", WH);
            if (n == 105) px(168, 220, 1'b1, "peak_f105_52", WH);
            if (n == 120) begin
                px(164, 220, 1'b1, "peak_settle_50", WH);
                px(168, 220, 1'b1, "peak_settle_52dim", GD);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
